// File: rtl/render_pkg.sv
// Shared types and constants for the render-cache triangle fetch path.
package render_pkg;

  localparam int TRI_COORD_W   = 32;
  localparam int WORDS_PER_TRI = 9;

  localparam int X0 = 0;
  localparam int Y0 = 1;
  localparam int Z0 = 2;
  localparam int X1 = 3;
  localparam int Y1 = 4;
  localparam int Z1 = 5;
  localparam int X2 = 6;
  localparam int Y2 = 7;
  localparam int Z2 = 8;

  typedef logic signed [TRI_COORD_W-1:0] coord_t;

  // Last member lands in the least significant bits, so x0 is word 0 of tri_data.
  typedef struct packed {
    coord_t z2;
    coord_t y2;
    coord_t x2;
    coord_t z1;
    coord_t y1;
    coord_t x1;
    coord_t z0;
    coord_t y0;
    coord_t x0;
  } tri_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUT,
    FINISH
  } fetch_state_t;

endpackage

// File: rtl/tri_cull.sv
// Back-face test on a screen-space triangle: the doubled signed area is formed at
// full precision and a non-positive area (clockwise or degenerate) flags a cull.
module tri_cull
  import render_pkg::*;
#(
  parameter int COORD_W = 32
) (
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  input  logic signed [COORD_W-1:0] x2,
  input  logic signed [COORD_W-1:0] y2,
  output logic                      cull
);

  localparam int AW = 2 * COORD_W + 2;

  logic signed [AW-1:0] ex0, ey0, ex1, ey1, ex2, ey2;
  logic signed [AW-1:0] area;

  always_comb begin
    ex0  = x0;
    ey0  = y0;
    ex1  = x1;
    ey1  = y1;
    ex2  = x2;
    ey2  = y2;
    area = (ex1 - ex0) * (ey2 - ey0) - (ex2 - ex0) * (ey1 - ey0);
    cull = area[AW-1] || (area == '0);
  end

endmodule

// File: rtl/tri_fetch.sv
// Render-cache triangle fetch: reads nine coordinate words per triangle and streams
// packed triangles to raster setup. Define TRI_FETCH_BACKFACE_CULL_EN to drop back faces.
module tri_fetch
  import render_pkg::*;
#(
  parameter int COORD_W = 32,
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [CNT_W-1:0]               tri_count,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [COORD_W-1:0]             mem_rd_data,
  output logic                           tri_valid,
  input  logic                           tri_ready,
  output logic [WORDS_PER_TRI*COORD_W-1:0] tri_data,
  output logic [CNT_W-1:0]               culled_count
);

  localparam int KW = 4;

  fetch_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    culled_q, culled_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       rd_k_q, rd_k_d;
  logic                rd_vld_q, rd_vld_d;
  logic [COORD_W-1:0]  words_q [WORDS_PER_TRI];
  logic [COORD_W-1:0]  words_d [WORDS_PER_TRI];
  logic                cull;
  logic                last_tri;

`ifdef TRI_FETCH_BACKFACE_CULL_EN
  tri_cull #(.COORD_W(COORD_W)) u_cull (
    .x0   (words_q[X0]),
    .y0   (words_q[Y0]),
    .x1   (words_q[X1]),
    .y1   (words_q[Y1]),
    .x2   (words_q[X2]),
    .y2   (words_q[Y2]),
    .cull (cull)
  );
`else
  assign cull = 1'b0;
`endif

  // addr_q walks sequentially, so after the ninth read it already points at the next x0.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    idx_d     = idx_q;
    culled_d  = culled_q;
    k_d       = k_q;
    rd_k_d    = rd_k_q;
    rd_vld_d  = 1'b0;
    words_d   = words_q;
    mem_rd_en = 1'b0;
    last_tri  = (idx_q + CNT_W'(1)) == count_q;

    if (rd_vld_q) words_d[rd_k_q] = mem_rd_data;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          culled_d = '0;
          if (tri_count == '0) begin
            state_d = FINISH;
          end else begin
            count_d = tri_count;
            addr_d  = base_addr;
            idx_d   = '0;
            k_d     = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        rd_vld_d  = 1'b1;
        rd_k_d    = k_q;
        addr_d    = addr_q + ADDR_W'(1);
        if (k_q == KW'(WORDS_PER_TRI - 1)) state_d = DRAIN;
        else                                k_d     = k_q + KW'(1);
      end
      DRAIN: begin
        if (cull) begin
          if (culled_q != '1) culled_d = culled_q + CNT_W'(1);
          idx_d   = idx_q + CNT_W'(1);
          k_d     = '0;
          state_d = last_tri ? FINISH : FETCH;
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        // The handshake cycle also issues read 0 of the next triangle to keep a 10-cycle cadence.
        if (tri_ready) begin
          idx_d = idx_q + CNT_W'(1);
          if (last_tri) begin
            state_d = FINISH;
          end else begin
            mem_rd_en = 1'b1;
            rd_vld_d  = 1'b1;
            rd_k_d    = '0;
            addr_d    = addr_q + ADDR_W'(1);
            k_d       = KW'(1);
            state_d   = FETCH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      culled_q <= '0;
      k_q      <= '0;
      rd_k_q   <= '0;
      rd_vld_q <= 1'b0;
      words_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      culled_q <= culled_d;
      k_q      <= k_d;
      rd_k_q   <= rd_k_d;
      rd_vld_q <= rd_vld_d;
      words_q  <= words_d;
    end
  end

  assign busy         = (state_q == FETCH) || (state_q == DRAIN) || (state_q == OUT);
  assign done         = (state_q == FINISH);
  assign tri_valid    = (state_q == OUT);
  assign mem_addr     = addr_q;
  assign culled_count = culled_q;

  always_comb begin
    tri_data = '0;
    for (int k = 0; k < WORDS_PER_TRI; k++) tri_data[k*COORD_W +: COORD_W] = words_q[k];
  end

endmodule

// File: tb/tb_tri_fetch.sv
// Self-checking bench for tri_fetch with a synchronous-read memory model and a
// scoreboard of expected read addresses and triangles.
`timescale 1ns/1ps
module tb_tri_fetch;
  import render_pkg::*;

  localparam int CW = 32;
  localparam int AW = 16;
  localparam int NW = 16;

`ifdef TRI_FETCH_BACKFACE_CULL_EN
  localparam bit CULL_EN = 1'b1;
`else
  localparam bit CULL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [NW-1:0]   tri_count = '0;
  logic            busy, done, mem_rd_en, tri_valid;
  logic            tri_ready = 1'b1;
  logic [AW-1:0]   mem_addr;
  logic [CW-1:0]   mem_rd_data = '0;
  logic [9*CW-1:0] tri_data;
  logic [NW-1:0]   culled_count;

  int          tests = 0;
  int          fails = 0;
  int unsigned edges = 0;

  logic [CW-1:0] ovr [logic [AW-1:0]];

  tri_fetch #(.COORD_W(CW), .ADDR_W(AW), .CNT_W(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .tri_count    (tri_count),
    .busy         (busy),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .tri_valid    (tri_valid),
    .tri_ready    (tri_ready),
    .tri_data     (tri_data),
    .culled_count (culled_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic logic [CW-1:0] mem_word(input logic [AW-1:0] a);
    if (ovr.exists(a)) return ovr[a];
    return CW'(a);
  endfunction

  always @(posedge clk) if (mem_rd_en === 1'b1) mem_rd_data <= mem_word(mem_addr);

  function automatic bit model_cull(input tri_t t);
    logic signed [2*CW+1:0] ax0, ay0, ax1, ay1, ax2, ay2, area;
    ax0 = t.x0; ay0 = t.y0; ax1 = t.x1; ay1 = t.y1; ax2 = t.x2; ay2 = t.y2;
    area = (ax1 - ax0) * (ay2 - ay0) - (ax2 - ax0) * (ay1 - ay0);
    return CULL_EN && (area[2*CW+1] || area == '0);
  endfunction

  // Called at a falling edge; start is raised immediately and sampled on the next rising edge.
  task automatic run_job(input string nm, input logic [AW-1:0] base, input logic [NW-1:0] cnt,
                         input int stall, input int start_len);
    logic [AW-1:0]   exp_addr [$];
    logic [9*CW-1:0] exp_tri [$];
    logic [9*CW-1:0] tv, prev_d, want;
    logic [AW-1:0]   a, ea;
    int n_out, n_cull, first_idx, exp_first, exp_done, rel, stall_left;
    bit last_culled, seen_done, seen_first, prev_v, prev_hs;
    int unsigned s0;
    n_out = 0; n_cull = 0; first_idx = -1; last_culled = 1'b0; tv = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      for (int k = 0; k < 9; k++) begin
        a = base + AW'(9 * i + k);
        exp_addr.push_back(a);
        tv[k*CW +: CW] = mem_word(a);
      end
      if (model_cull(tv)) begin
        n_cull++; last_culled = 1'b1;
      end else begin
        exp_tri.push_back(tv);
        if (first_idx < 0) first_idx = i;
        n_out++; last_culled = 1'b0;
      end
    end
    exp_first = (first_idx < 0) ? -1 : 11 + 10 * first_idx;
    exp_done  = 10 * int'(cnt) + 1 + ((cnt != 0 && !last_culled) ? 1 : 0) + stall * n_out;

    start = 1'b1; base_addr = base; tri_count = cnt; tri_ready = 1'b1; s0 = edges;
    seen_done = 0; seen_first = 0; prev_v = 0; prev_hs = 0; prev_d = '0; stall_left = stall;
    for (int t = 0; t < exp_done + 40 && !seen_done; t++) begin
      @(negedge clk);
      rel   = int'(edges - s0);
      start = (rel < start_len);
      if (tri_valid === 1'b1 && stall_left > 0) begin
        tri_ready = 1'b0; stall_left--;
      end else begin
        tri_ready = 1'b1;
      end
      #1;
      tests++;
      if (busy !== (rel < exp_done)) begin
        fails++; $display("FAIL %s busy rel=%0d got %b want %b", nm, rel, busy, rel < exp_done);
      end
      if (mem_rd_en === 1'b1) begin
        tests++;
        if (exp_addr.size() == 0) begin
          fails++; $display("FAIL %s extra_read rel=%0d addr=%h", nm, rel, mem_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (mem_addr !== ea) begin
            fails++; $display("FAIL %s rd_addr rel=%0d got %h want %h", nm, rel, mem_addr, ea);
          end
        end
      end
      if (tri_valid === 1'b1 && tri_ready === 1'b0) begin
        tests++;
        if (mem_rd_en !== 1'b0) begin
          fails++; $display("FAIL %s read_in_stall rel=%0d got %b want 0", nm, rel, mem_rd_en);
        end
      end
      if (prev_v && !prev_hs) begin
        tests++;
        if (tri_valid !== 1'b1 || tri_data !== prev_d) begin
          fails++; $display("FAIL %s hold rel=%0d valid=%b data=%h want %h", nm, rel, tri_valid, tri_data, prev_d);
        end
      end
      if (tri_valid === 1'b1 && !seen_first) begin
        seen_first = 1; tests++;
        if (rel != exp_first) begin
          fails++; $display("FAIL %s first_valid got %0d want %0d", nm, rel, exp_first);
        end
      end
      if (tri_valid === 1'b1 && tri_ready === 1'b1) begin
        stall_left = stall; tests++;
        if (exp_tri.size() == 0) begin
          fails++; $display("FAIL %s extra_tri rel=%0d data=%h", nm, rel, tri_data);
        end else begin
          want = exp_tri.pop_front();
          if (tri_data !== want) begin
            fails++; $display("FAIL %s tri_data rel=%0d got %h want %h", nm, rel, tri_data, want);
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1; tests++;
        if (rel != exp_done) begin
          fails++; $display("FAIL %s done_time got %0d want %0d", nm, rel, exp_done);
        end
      end
      prev_v  = (tri_valid === 1'b1);
      prev_hs = prev_v && (tri_ready === 1'b1);
      prev_d  = tri_data;
    end
    tests++;
    if (!seen_done) begin
      fails++; $display("FAIL %s timeout got no_done want done_at %0d", nm, exp_done);
    end
    tests++;
    if (exp_addr.size() != 0 || exp_tri.size() != 0) begin
      fails++; $display("FAIL %s leftovers got reads=%0d tris=%0d want 0 0", nm, exp_addr.size(), exp_tri.size());
    end
    tests++;
    if (culled_count !== NW'(n_cull)) begin
      fails++; $display("FAIL %s culled_count got %0d want %0d", nm, culled_count, n_cull);
    end
    @(negedge clk);
    start = 1'b0; tri_ready = 1'b1;
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; base_addr = 16'h1234; tri_count = 16'd5; tri_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done got %b want 0", done); end
    tests++; if (mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset rd_en got %b want 0", mem_rd_en); end
    tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset addr got %h want 0", mem_addr); end
    tests++; if (tri_valid !== 1'b0) begin fails++; $display("FAIL reset valid got %b want 0", tri_valid); end
    tests++; if (tri_data !== '0) begin fails++; $display("FAIL reset data got %h want 0", tri_data); end
    tests++; if (culled_count !== '0) begin fails++; $display("FAIL reset culled got %0d want 0", culled_count); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_job("basic", 16'h0010, 16'd2, 0, 1);
  endtask

  task automatic test_zero_count;
    run_job("zero_count", 16'h0077, 16'd0, 0, 2);
  endtask

  task automatic test_backpressure;
    run_job("backpressure", 16'h0100, 16'd2, 5, 1);
  endtask

  task automatic test_wrap;
    run_job("wrap", 16'hFFFC, 16'd1, 0, 1);
  endtask

  task automatic test_abort;
    start = 1'b1; base_addr = 16'h0040; tri_count = 16'd3; tri_ready = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk);
      if (r == 1) begin
        start = 1'b1; base_addr = 16'h0500; tri_count = 16'd1;
      end else begin
        start = 1'b0;
      end
      #1;
      tests++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0040 + AW'(r - 1)) begin
        fails++; $display("FAIL abort fetch r=%0d got en=%b addr=%h want 1 %h", r, mem_rd_en, mem_addr, 16'h0040 + AW'(r - 1));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if ({busy, done, mem_rd_en, tri_valid} !== 4'b0 || mem_addr !== '0 || tri_data !== '0 || culled_count !== '0) begin
      fails++; $display("FAIL abort outputs got busy=%b done=%b en=%b valid=%b addr=%h want all 0", busy, done, mem_rd_en, tri_valid, mem_addr);
    end
    rst = 1'b0;
    run_job("restart", 16'h0200, 16'd1, 0, 1);
  endtask

  task automatic test_cull;
    logic [CW-1:0] w [27];
    w = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0005,
          32'h0004_0000, 32'h0000_0000, 32'h0000_0005,
          32'h0000_0000, 32'h0004_0000, 32'h0000_0005,
          32'h0000_0000, 32'h0000_0000, 32'h0000_0006,
          32'h0000_0000, 32'h0004_0000, 32'h0000_0006,
          32'h0004_0000, 32'h0000_0000, 32'h0000_0006,
          32'h0000_0000, 32'h0000_0000, 32'h0000_0007,
          32'h0001_0000, 32'h0001_0000, 32'h0000_0007,
          32'h0002_0000, 32'h0002_0000, 32'h0000_0007};
    for (int i = 0; i < 27; i++) ovr[16'h0300 + AW'(i)] = w[i];
    run_job("cull", 16'h0300, 16'd3, 0, 1);
    ovr.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_wrap();
    test_abort();
    test_cull();
    run_job("back_to_back", 16'h0020, 16'd3, 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tri_fetch.md
Name: tri_fetch

Overview:
- Reader side of the render-cache screen-coordinate buffer, which the geometric transform stage fills with nine words per triangle (x0,y0,z0,x1,y1,z1,x2,y2,z2).
- On a start command, walks the triangles of one model's cache, assembles each into a packed triangle, and hands it to the rasterizer over a valid/ready stream.
- Sits between the render-cache memory (synchronous read port) and the raster setup stage.

Parameters:
- COORD_W, 32, width of one screen coordinate word (signed Q16.16).
- ADDR_W, 16, word-address width of the render-cache memory.
- CNT_W, 16, width of the triangle count and culled counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base_addr  in  ADDR_W  word address of the first triangle's x0; sampled on an accepted start.
- tri_count  in  CNT_W  number of triangles to fetch; sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the job completes.
- mem_rd_en  out  1  read strobe to the render-cache memory.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  COORD_W  read data, valid exactly one cycle after mem_rd_en.
- tri_valid  out  1  triangle output valid.
- tri_ready  in  1  downstream ready.
- tri_data  out  9*COORD_W  word k occupies bits [k*COORD_W +: COORD_W], k=0 is x0.
- culled_count  out  CNT_W  triangles dropped in the current/last job; reset on accepted start.

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, tri_valid=0, tri_data=0, culled_count=0; FSM goes to IDLE.
- FSM states: IDLE, FETCH, DRAIN, OUT, FINISH.
- IDLE: a start sets busy next cycle.
  - tri_count=0 goes directly to FINISH.
  - Otherwise latches base and count, clears tri_idx and culled_count, and goes to FETCH.
- FETCH: issues 9 consecutive reads, k=0..8, one per cycle.
  - mem_addr = base + 9*tri_idx + k, modulo 2^ADDR_W; wrap-around is legal and silent.
  - Data returned for read k is captured into word k one cycle later.
  - After k=8 goes to DRAIN.
- DRAIN: one cycle to capture word 8. Then goes to OUT, or, if the triangle is culled, increments culled_count and advances.
- OUT: tri_valid=1; tri_data is held stable until tri_valid & tri_ready.
  - tri_valid never deasserts without a handshake.
  - tri_ready may be high before valid; it has no effect.
- Advance after handshake or cull: tri_idx += 1. If tri_idx == count, go to FINISH; else go to FETCH.
- Latency: first mem_rd_en is 1 cycle after start; first tri_valid is 11 cycles after start; steady state is 10 cycles per triangle plus backpressure.
- FINISH: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- A start during busy is dropped. A start in the FINISH cycle is dropped.
- rst mid-job aborts immediately: no done pulse, outputs return to reset values.

Optional Feature:
- Macro: TRI_FETCH_BACKFACE_CULL_EN.
- Defined:
  - In DRAIN, compute area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), signed, at full 2*COORD_W+2 bits with no truncation.
  - area <= 0 means culled: not presented on the stream, culled_count += 1 (saturating at all-ones).
  - Degenerate (area=0) triangles are culled.
- Undefined: no triangles are culled and culled_count stays 0.
- Port list is identical in both builds.

Decomposition:
- Package render_pkg holds:
  - WORDS_PER_TRI = 9.
  - Word index constants X0..Z2.
  - Typedef coord_t (signed COORD_W).
  - Packed struct tri_t, nine coord_t, x0 in the least significant position, matching tri_data.
- One sub-module, tri_cull: combinational signed-area compute producing a cull flag. It is instantiated only under the macro.

Test Plan:
- Start with base=0x0010, count=2, memory word n = n, tri_ready=1:
  - reads at addresses 0x10..0x21;
  - first tri_valid at start+11 with word0=0x10 and word8=0x18;
  - second triangle has word0=0x19;
  - done occurs at start+22.
- Count=0: busy stays 0 and done pulses at start+1; no mem_rd_en.
- Backpressure: hold tri_ready=0 for 5 cycles after tri_valid -> tri_data is unchanged and tri_valid is held; no new reads are issued until the handshake.
- Wrap: base=0xFFFC, count=1 -> addresses 0xFFFC..0xFFFF, then 0x0000..0x0004.
- Second start while busy, then rst asserted at cycle 5 of FETCH:
  - the second start is ignored;
  - after rst, all outputs are 0, there is no done pulse, and a new start is accepted next cycle.
- With TRI_FETCH_BACKFACE_CULL_EN, three triangles:
  - CCW (0,0),(4,0),(0,4) has area 16 and is output;
  - CW (0,0),(0,4),(4,0) is culled;
  - collinear (0,0),(1,1),(2,2) is culled;
  - result: one handshake, culled_count=2.
